mult3_serial_tx: RTL and testbench

- Transmit-side companion to the serial divisible-by-3 detector.
- Accepts a parallel WIDTH-bit word over a valid/ready handshake and serializes it MSB-first, one bit per clock, on the detector's serial input line.
- Alongside each bit it drives the golden "divisible by 3 so far" flag, computed from a running mod-3 residue, so benches and on-board self-test can drive and check the detector.

---
 rtl/mult3_pkg.sv | 36 +++
 rtl/mult3_residue.sv | 39 +++
 rtl/mult3_serial_tx.sv | 182 ++++++++++++++++++
 tb/tb_mult3_serial_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult3_pkg
// Description : Shared definitions for the divisible-by-3 serial transmitter:
//               residue encoding, transmitter state encoding and the mod-3
//               residue step function.
// Revision    : 1.0 - initial release
// ============================================================================
package mult3_pkg;

   // Residue encoding for the running value mod 3
   localparam logic [1:0] R0 = 2'd0;
   localparam logic [1:0] R1 = 2'd1;
   localparam logic [1:0] R2 = 2'd2;

   // Transmitter states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } tx_state_t;

   // Fold one more bit (LSB side) into a residue: (2*r + b) mod 3
   function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
      logic [1:0] res;
      case (r)
         R0:      res = b ? R1 : R0;
         R1:      res = b ? R0 : R2;
         R2:      res = b ? R2 : R1;
         default: res = R0;
      endcase
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mult3_residue.sv
`default_nettype none
// ============================================================================
// Module      : mult3_residue
// Description : 2-bit running mod-3 residue register. 'start' folds the bit
//               into a zero residue (new frame), 'step' folds it into the
//               stored residue, 'clr' returns the register to zero.
//               r_next is the combinational post-fold residue.
// Revision    : 1.0 - initial release
// ============================================================================
module mult3_residue
   import mult3_pkg::*;
(
   input  logic       clk,
   input  logic       rst,      // asynchronous, active-low
   input  logic       clr,
   input  logic       start,
   input  logic       step,
   input  logic       bit_in,
   output logic [1:0] r_next
);

   logic [1:0] r;

   // A new frame restarts from zero before its first bit is folded in
   assign r_next = mod3_step(start ? R0 : r, bit_in);

   // Residue register: fold has priority over clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r <= R0;
      end else if (start || step) begin
         r <= r_next;
      end else if (clr) begin
         r <= R0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mult3_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : mult3_serial_tx
// Description : Serializes a WIDTH-bit word MSB-first, one bit per clock, and
//               drives alongside each bit the golden "divisible by 3 so far"
//               flag. Optional GAP idle cycles between frames.
//               Macro MULT3_TX_CHECK_EN adds a checker comparing the
//               detector output (div_in) with the one-cycle-delayed exp_div.
// Revision    : 1.0 - initial release
// ============================================================================
module mult3_serial_tx
   import mult3_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst,        // asynchronous, active-low
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             sout,
   output logic             sout_valid,
   output logic             sof,
   output logic             eof,
   output logic             exp_div,
   output logic             busy
`ifdef MULT3_TX_CHECK_EN
   ,
   input  logic             div_in,
   output logic             mismatch,
   output logic [15:0]      err_count
`endif
);

   localparam int CW       = $clog2(WIDTH);
   localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

   tx_state_t        state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    bits_left, bits_nxt;
   logic [3:0]       gap_left, gap_nxt;
   logic             sout_nxt, valid_nxt, sof_nxt, eof_nxt, div_nxt;
   logic             res_clr, res_start, res_step, res_bit;
   logic [1:0]       r_next;
   logic             accept;

   // Ready in IDLE, in the eof cycle when frames run back-to-back, and in the
   // final gap cycle
   assign load_ready = (state == ST_IDLE)
                     || ((state == ST_SHIFT) && eof && (GAP == 0))
                     || ((state == ST_GAP) && (gap_left == 4'd0));
   assign accept     = load_valid && load_ready;
   assign busy       = (state != ST_IDLE);

   mult3_residue u_residue (
      .clk    (clk),
      .rst    (rst),
      .clr    (res_clr),
      .start  (res_start),
      .step   (res_step),
      .bit_in (res_bit),
      .r_next (r_next)
   );

   // State register and registered frame outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         shreg      <= '0;
         bits_left  <= '0;
         gap_left   <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         sof        <= 1'b0;
         eof        <= 1'b0;
         exp_div    <= 1'b0;
      end else begin
         state      <= state_nxt;
         shreg      <= shreg_nxt;
         bits_left  <= bits_nxt;
         gap_left   <= gap_nxt;
         sout       <= sout_nxt;
         sout_valid <= valid_nxt;
         sof        <= sof_nxt;
         eof        <= eof_nxt;
         exp_div    <= div_nxt;
      end
   end

   // Next-state, shift and residue control; outputs default to the idle zeros
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      bits_nxt  = bits_left;
      gap_nxt   = gap_left;
      sout_nxt  = 1'b0;
      valid_nxt = 1'b0;
      sof_nxt   = 1'b0;
      eof_nxt   = 1'b0;
      div_nxt   = 1'b0;
      res_clr   = 1'b0;
      res_start = 1'b0;
      res_step  = 1'b0;
      res_bit   = 1'b0;

      if (accept) begin
         // Launch a new frame: MSB goes out next cycle with sof
         res_start = 1'b1;
         res_bit   = load_data[WIDTH-1];
         sout_nxt  = load_data[WIDTH-1];
         valid_nxt = 1'b1;
         sof_nxt   = 1'b1;
         div_nxt   = (r_next == R0);
         shreg_nxt = {load_data[WIDTH-2:0], 1'b0};
         bits_nxt  = CW'(WIDTH - 1);
         state_nxt = ST_SHIFT;
      end else begin
         case (state)
            ST_SHIFT: begin
               if (!eof) begin
                  res_step  = 1'b1;
                  res_bit   = shreg[WIDTH-1];
                  sout_nxt  = shreg[WIDTH-1];
                  valid_nxt = 1'b1;
                  eof_nxt   = (bits_left == CW'(1));
                  div_nxt   = (r_next == R0);
                  shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
                  bits_nxt  = bits_left - CW'(1);
               end else begin
                  res_clr = 1'b1;
                  if (GAP == 0) begin
                     state_nxt = ST_IDLE;
                  end else begin
                     state_nxt = ST_GAP;
                     gap_nxt   = 4'(GAP_LAST);
                  end
               end
            end
            ST_GAP: begin
               if (gap_left == 4'd0) begin
                  state_nxt = ST_IDLE;
               end else begin
                  gap_nxt = gap_left - 4'd1;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

`ifdef MULT3_TX_CHECK_EN
   logic exp_div_d;
   logic valid_d;

   // Delay the golden flag one cycle to line up with the detector's register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_div_d <= 1'b0;
         valid_d   <= 1'b0;
      end else begin
         exp_div_d <= exp_div;
         valid_d   <= sout_valid;
      end
   end

   assign mismatch = valid_d && (div_in != exp_div_d);

   // Saturating error counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_count <= 16'h0000;
      end else if (mismatch && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'h0001;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult3_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult3_serial_tx
// Description : Scoreboard bench for mult3_serial_tx. Two instances: GAP=0
//               (index 0) and GAP=3 (index 1). The driver pushes the expected
//               bit stream (value, divisible-by-3 flag of the prefix, sof,
//               eof, cycle) when a word is accepted; a negedge monitor pops
//               and compares whenever sout_valid is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult3_serial_tx;

   localparam int W = 8;

   typedef struct packed {
      logic [3:0] f;      // {sout, exp_div, sof, eof}
      int         cyc;
   } item_t;

   logic         clk;
   logic         rst;
   logic         valid [2];
   logic [W-1:0] data  [2];
   logic         ready [2];
   logic         sout  [2];
   logic         sv    [2];
   logic         sof   [2];
   logic         eof   [2];
   logic         ed    [2];
   logic         busy  [2];

   int    cyc;
   int    checks;
   int    errors;
   int    earliest [2];
   item_t q0[$];
   item_t q1[$];

`ifdef MULT3_TX_CHECK_EN
   logic        div_in0, div_in1, inj;
   logic        ed_d0, ed_d1;
   logic        mm0, mm1;
   logic [15:0] ec0, ec1;
   int          mm_pulses;
   assign div_in0 = ed_d0 ^ inj;
   assign div_in1 = ed_d1;
   always @(posedge clk) begin
      ed_d0 <= ed[0];
      ed_d1 <= ed[1];
   end
   always @(negedge clk) if (mm0 === 1'b1) mm_pulses <= mm_pulses + 1;
`endif

   mult3_serial_tx #(.WIDTH(W), .GAP(0)) dut0 (
      .clk        (clk),
      .rst        (rst),
      .load_valid (valid[0]),
      .load_ready (ready[0]),
      .load_data  (data[0]),
      .sout       (sout[0]),
      .sout_valid (sv[0]),
      .sof        (sof[0]),
      .eof        (eof[0]),
      .exp_div    (ed[0]),
      .busy       (busy[0])
`ifdef MULT3_TX_CHECK_EN
      ,
      .div_in     (div_in0),
      .mismatch   (mm0),
      .err_count  (ec0)
`endif
   );

   mult3_serial_tx #(.WIDTH(W), .GAP(3)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .load_valid (valid[1]),
      .load_ready (ready[1]),
      .load_data  (data[1]),
      .sout       (sout[1]),
      .sout_valid (sv[1]),
      .sof        (sof[1]),
      .eof        (eof[1]),
      .exp_div    (ed[1]),
      .busy       (busy[1])
`ifdef MULT3_TX_CHECK_EN
      ,
      .div_in     (div_in1),
      .mismatch   (mm1),
      .err_count  (ec1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int gap_of(input int p);
      return (p == 0) ? 0 : 3;
   endfunction

   // Reference: bit i of the frame is data bit W-1-i; the flag is whether the
   // value formed by the bits sent so far is a multiple of 3
   task automatic push_frame(input int p, input logic [W-1:0] d, input int e);
      item_t it;
      int    pre;
      for (int i = 0; i < W; i++) begin
         pre      = int'(d) >> (W - 1 - i);
         it.f[3]  = pre[0];
         it.f[2]  = ((pre % 3) == 0);
         it.f[1]  = (i == 0);
         it.f[0]  = (i == W - 1);
         it.cyc   = e + i;
         if (p == 0) q0.push_back(it);
         else        q1.push_back(it);
      end
   endtask

   // Offer a word (call at a negedge); returns at the negedge after accept
   task automatic send(input int p, input logic [W-1:0] d);
      int t;
      int exp_edge;
      int e;
      valid[p] = 1'b1;
      data[p]  = d;
      exp_edge = (cyc + 1 > earliest[p]) ? cyc + 1 : earliest[p];
      t = 0;
      while (!ready[p] && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         chk($sformatf("ready_timeout%0d", p), 0, 1);
      end else begin
         e = cyc + 1;
         chk($sformatf("accept_edge%0d", p), e, exp_edge);
         push_frame(p, d, e);
         earliest[p] = e + W + gap_of(p);
      end
      @(negedge clk);
      valid[p] = 1'b0;
      data[p]  = W'($urandom);
   endtask

   task automatic wait_idle(input int p);
      int t;
      t = 0;
      while (((p == 0) ? (q0.size() != 0 || busy[0]) : (q1.size() != 0 || busy[1])) && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk($sformatf("idle_timeout%0d", p), (t >= 300) ? 1 : 0, 0);
   endtask

   task automatic mon(input int p);
      item_t it;
      if (sv[p]) begin
         chk($sformatf("busy_in_frame%0d", p), longint'(busy[p]), 1);
         if ((p == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            chk($sformatf("unexpected_bit%0d", p), 1, 0);
         end else begin
            it = (p == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("bit{sout,div,sof,eof}%0d", p),
                longint'({sout[p], ed[p], sof[p], eof[p]}), longint'(it.f));
            chk($sformatf("bit_cycle%0d", p), cyc, it.cyc);
         end
      end else begin
         chk($sformatf("idle_zero%0d", p), longint'({sout[p], ed[p], sof[p], eof[p]}), 0);
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc      = 0;
      checks   = 0;
      errors   = 0;
      rst      = 1'b0;
      valid[0] = 1'b0; valid[1] = 1'b0;
      data[0]  = '0;   data[1]  = '0;
      earliest[0] = 0; earliest[1] = 0;
`ifdef MULT3_TX_CHECK_EN
      inj = 1'b0;
      mm_pulses = 0;
`endif
      repeat (3) @(negedge clk);
      chk("reset_outputs", longint'({sout[0], sv[0], sof[0], eof[0], ed[0], busy[0]}), 0);
      chk("reset_busy1", longint'(busy[1]), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_reset0", longint'(ready[0]), 1);
      chk("ready_after_reset1", longint'(ready[1]), 1);

      // Directed frames on the GAP=0 instance
      send(0, 8'hB4);
      wait_idle(0);
      send(0, 8'hD3);
`ifdef MULT3_TX_CHECK_EN
      @(negedge clk);
      #2 inj = 1'b1;
      @(negedge clk);
      #2 inj = 1'b0;
`endif
      wait_idle(0);
      send(0, 8'hB4);
      send(0, 8'h03);
      wait_idle(0);

      // Random words with random spacing (spacing 0 gives back-to-back)
      repeat (20) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(0, W'($urandom));
      end
      wait_idle(0);

      // GAP=3 instance: directed pair then random traffic
      send(1, 8'hB4);
      send(1, 8'h03);
      repeat (10) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         send(1, W'($urandom));
      end
      wait_idle(1);

      // Asynchronous reset in the middle of a frame
      send(0, 8'hFF);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_reset_outputs", longint'({sout[0], sv[0], sof[0], eof[0], ed[0], busy[0]}), 0);
      q0.delete();
      q1.delete();
      earliest[0] = 0;
      earliest[1] = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_abort", longint'(ready[0]), 1);
      send(0, 8'h06);
      wait_idle(0);

`ifdef MULT3_TX_CHECK_EN
      chk("mismatch_pulses", mm_pulses, 1);
      chk("err_count0", longint'(ec0), 1);
      chk("err_count1", longint'(ec1), 0);
`endif
      chk("queue0_drained", q0.size(), 0);
      chk("queue1_drained", q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
